// File: rtl/rr_dest_encoder.sv
// Round-robin 8-to-3 write-request encoder feeding the register-file write port.
// Registers the winning index as destreg behind a valid/ready handshake and returns a one-cycle grant.
module rr_dest_encoder #(
    parameter int N  = 8,
    parameter int W  = 3,
    parameter int RR = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] destreg,
    output logic [N-1:0] grant,
    output logic         busy
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] destreg_q, destreg_d;
    logic [N-1:0] grant_q, grant_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         slot_free;
    logic         found;
    logic [W-1:0] idx;
    logic [W-1:0] scan_start;
    logic [W-1:0] cand;

    assign slot_free = ~out_valid_q | out_ready;

    // Scan from the pointer (or from 0 in fixed mode); index arithmetic wraps at W bits.
    always_comb begin
        found      = 1'b0;
        idx        = '0;
        cand       = '0;
        scan_start = (RR != 0) ? ptr_q : '0;
        for (int i = 0; i < N; i++) begin
            cand = scan_start + W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        destreg_d   = destreg_q;
        grant_d     = '0;
        ptr_d       = ptr_q;
        if (slot_free) begin
            if (found) begin
                out_valid_d = 1'b1;
                destreg_d   = idx;
                grant_d     = N'(1) << idx;
                ptr_d       = idx + W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // A held transfer is dropped on reset, not replayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            destreg_q   <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            destreg_q   <= destreg_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign destreg   = destreg_q;
    assign grant     = grant_q;
    assign busy      = out_valid_q & ~out_ready;

endmodule

// File: tb/tb_rr_dest_encoder.sv
// Bench for rr_dest_encoder: round-robin and fixed-priority instances share stimulus
// and are compared each cycle against a per-instance behavioural model.
module tb_rr_dest_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       out_ready;

    logic       vld_rr, vld_fx;
    logic [2:0] dst_rr, dst_fx;
    logic [7:0] gnt_rr, gnt_fx;
    logic       bsy_rr, bsy_fx;

    int n_vec = 0;
    int n_err = 0;

    // model state, index 0 = round-robin instance, 1 = fixed-priority instance
    int m_v[2];
    int m_d[2];
    int m_g[2];
    int m_p[2];

    rr_dest_encoder #(.N(8), .W(3), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(vld_rr), .destreg(dst_rr), .grant(gnt_rr), .busy(bsy_rr)
    );

    rr_dest_encoder #(.N(8), .W(3), .RR(0)) u_fx (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(vld_fx), .destreg(dst_fx), .grant(gnt_fx), .busy(bsy_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] rq, input logic rdy);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_v[k] = 0; m_d[k] = 0; m_g[k] = 0; m_p[k] = 0;
            end else if (m_v[k] == 0 || rdy) begin
                if (rq != 8'h00) begin
                    int start;
                    int win;
                    start = (k == 0) ? m_p[k] : 0;
                    win = -1;
                    for (int off = 0; off < 8; off++) begin
                        int j;
                        j = (start + off) % 8;
                        if (win < 0 && rq[j]) win = j;
                    end
                    m_v[k] = 1;
                    m_d[k] = win;
                    m_g[k] = 1 << win;
                    m_p[k] = (win + 1) % 8;
                end else begin
                    m_v[k] = 0;
                    m_g[k] = 0;
                end
            end else begin
                m_g[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        int exp_busy0, exp_busy1;
        exp_busy0 = (m_v[0] != 0 && !out_ready) ? 1 : 0;
        exp_busy1 = (m_v[1] != 0 && !out_ready) ? 1 : 0;
        chk("rr_valid", {31'd0, vld_rr}, m_v[0]);
        chk("rr_dest",  {29'd0, dst_rr}, m_d[0]);
        chk("rr_grant", {24'd0, gnt_rr}, m_g[0]);
        chk("rr_busy",  {31'd0, bsy_rr}, exp_busy0);
        chk("fx_valid", {31'd0, vld_fx}, m_v[1]);
        chk("fx_dest",  {29'd0, dst_fx}, m_d[1]);
        chk("fx_grant", {24'd0, gnt_fx}, m_g[1]);
        chk("fx_busy",  {31'd0, bsy_fx}, exp_busy1);
    endtask

    // Drive inputs away from the edge, clock once, then check on the falling edge.
    task automatic tick(input logic r, input logic [7:0] rq, input logic rdy);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        @(posedge clk);
        model_step(r, rq, rdy);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b1; req = 8'hFF; out_ready = 1'b1;

        // reset with all requests pending
        tick(1'b1, 8'hFF, 1'b1);
        tick(1'b1, 8'hFF, 1'b1);
        chk("rst_valid", {31'd0, vld_rr}, 32'd0);
        chk("rst_grant", {24'd0, gnt_rr}, 32'd0);
        chk("rst_dest",  {29'd0, dst_rr}, 32'd0);
        tick(1'b0, 8'hFF, 1'b1);
        chk("first_grant", {24'd0, gnt_rr}, 32'h01);
        chk("first_dest",  {29'd0, dst_rr}, 32'd0);

        // single requests walking across all sources
        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            one = 8'h01 << i;
            tick(1'b0, one, 1'b1);
            chk("single_dest",  {29'd0, dst_rr}, i);
            chk("single_grant", {24'd0, gnt_rr}, {24'd0, one});
        end

        // all requests held: strict rotation
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'hFF, 1'b1);
            chk("rr_seq", {29'd0, dst_rr}, i % 8);
            chk("fx_seq", {29'd0, dst_fx}, 32'd0);
        end

        // pointer wrap: grant 5 (ptr 6), then sources 0 and 2
        tick(1'b0, 8'h20, 1'b1);
        chk("wrap_5", {29'd0, dst_rr}, 32'd5);
        tick(1'b0, 8'h05, 1'b1);
        chk("wrap_0", {29'd0, dst_rr}, 32'd0);
        tick(1'b0, 8'h04, 1'b1);
        chk("wrap_2", {29'd0, dst_rr}, 32'd2);
        tick(1'b0, 8'hFF, 1'b1);
        chk("wrap_ptr3", {29'd0, dst_rr}, 32'd3);

        // stall holding destreg 3 while source 4 waits
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h08, 1'b1);
        chk("stall_pre", {29'd0, dst_rr}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h10, 1'b0);
            chk("stall_dest",  {29'd0, dst_rr}, 32'd3);
            chk("stall_grant", {24'd0, gnt_rr}, 32'd0);
            chk("stall_busy",  {31'd0, bsy_rr}, 32'd1);
        end
        tick(1'b0, 8'h10, 1'b1);
        chk("unstall_dest",  {29'd0, dst_rr}, 32'd4);
        chk("unstall_grant", {24'd0, gnt_rr}, 32'h10);

        // reset during a stall drops the held item and clears the pointer
        tick(1'b0, 8'h20, 1'b0);
        tick(1'b1, 8'h20, 1'b0);
        chk("midrst_valid", {31'd0, vld_rr}, 32'd0);
        tick(1'b0, 8'hFF, 1'b1);
        chk("midrst_ptr0", {29'd0, dst_rr}, 32'd0);

        // fixed priority always picks source 5 from 1010_0000
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'hA0, 1'b1);
            chk("fixed_5", {29'd0, dst_fx}, 32'd5);
        end

        // randomized traffic with occasional stalls and resets
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [7:0] rq;
            logic       rdy;
            r   = ($urandom_range(0, 99) == 0);
            rq  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            tick(r, rq, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
